// File: rtl/hazard_control_if.sv
// Decode/execute hazard bus between the pipeline and hazard_control.
interface hazard_control_if;
   logic [4:0]  a0;
   logic [4:0]  a1;
   logic [4:0]  a2_hazard;
   logic        dec_en_reg_wr;
   logic [2:0]  dec_ld_code;
   logic        jmp_taken;
   logic        mem_busy;
   logic        dec_stall;
   logic        dec_squash;
   logic        hold_fetch;
   logic [1:0]  fwd_sel_a;
   logic [1:0]  fwd_sel_b;
   logic [15:0] bubble_cnt;

   modport master (
      output a0, a1, a2_hazard, dec_en_reg_wr, dec_ld_code, jmp_taken, mem_busy,
      input  dec_stall, dec_squash, hold_fetch, fwd_sel_a, fwd_sel_b, bubble_cnt
   );

   modport slave (
      input  a0, a1, a2_hazard, dec_en_reg_wr, dec_ld_code, jmp_taken, mem_busy,
      output dec_stall, dec_squash, hold_fetch, fwd_sel_a, fwd_sel_b, bubble_cnt
   );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard control: EX/MEM/WB scoreboard, interlock/forward select, jump squash.
// Define HAZARD_FORWARD_EN for load-use-only stalls with operand forwarding.
module hazard_control #(
   parameter int unsigned SQUASH_CYCLES = 2,
   parameter logic [2:0]  LD_MEM        = 3'b001
) (
   input  logic             clk,
   input  logic             rst,
   hazard_control_if.slave  bus
);

   localparam int unsigned SB_DEPTH = 3;
   localparam int unsigned CW       = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
   localparam logic [CW-1:0] SQ_LOAD = CW'(SQUASH_CYCLES - 1);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } sb_entry_t;

   // index 0 = EX, 1 = MEM, 2 = WB
   sb_entry_t             sb [SB_DEPTH];
   logic [CW-1:0]         sq_cnt;
   logic [15:0]           bubble_q;

   logic [SB_DEPTH-1:0]   hit_a;
   logic [SB_DEPTH-1:0]   hit_b;
   logic                  hazard;
   logic                  squashing;
   logic                  bubble;
   logic                  squash;
   logic [1:0]            sel_a;
   logic [1:0]            sel_b;

   function automatic logic src_hit(input sb_entry_t e, input logic [4:0] s);
      return e.valid && (e.rd == s) && (s != 5'd0);
   endfunction

   function automatic logic [1:0] youngest(input logic [SB_DEPTH-1:0] h);
      if (h[0])      return 2'd1;
      else if (h[1]) return 2'd2;
      else if (h[2]) return 2'd3;
      else           return 2'd0;
   endfunction

   // Source match against every scoreboard stage
   always_comb begin
      hit_a = '0;
      hit_b = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         hit_a[i] = src_hit(sb[i], bus.a0);
         hit_b[i] = src_hit(sb[i], bus.a1);
      end
   end

`ifdef HAZARD_FORWARD_EN
   // Only a load still in EX cannot be forwarded in time
   always_comb begin
      hazard = (hit_a[0] | hit_b[0]) & sb[0].is_load;
      sel_a  = youngest(hit_a);
      sel_b  = youngest(hit_b);
   end
`else
   always_comb begin
      hazard = (|hit_a) | (|hit_b);
      sel_a  = youngest(hit_a) & 2'b00;
      sel_b  = youngest(hit_b) & 2'b00;
   end
`endif

   // A jump (or its trailing squash) takes priority over a hazard stall
   always_comb begin
      squashing = bus.jmp_taken | (sq_cnt != '0);
      bubble    = hazard & ~squashing;
      squash    = squashing | bubble;
   end

   assign bus.dec_squash = squash;
   assign bus.hold_fetch = bus.mem_busy | bubble;
   assign bus.dec_stall  = bus.mem_busy;
   assign bus.fwd_sel_a  = sel_a;
   assign bus.fwd_sel_b  = sel_b;
   assign bus.bubble_cnt = bubble_q;

   // Scoreboard advances with the pipeline and freezes while memory is busy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
      end else if (!bus.mem_busy) begin
         sb[0] <= '{valid:   bus.dec_en_reg_wr & ~squash,
                    rd:      bus.a2_hazard,
                    is_load: (bus.dec_ld_code == LD_MEM)};
         sb[1] <= sb[0];
         sb[2] <= sb[1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sq_cnt <= '0;
      end else if (bus.jmp_taken) begin
         sq_cnt <= SQ_LOAD;
      end else if (!bus.mem_busy && (sq_cnt != '0)) begin
         sq_cnt <= sq_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_q <= '0;
      end else if (bubble && !bus.mem_busy && (bubble_q != 16'hFFFF)) begin
         bubble_q <= bubble_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios plus random stimulus vs a history model.
module tb_hazard_control;

   localparam int unsigned SQ     = 2;
   localparam int          LD_VAL = 1;

   logic clk;
   logic rst;

   hazard_control_if ifc ();

   hazard_control #(
      .SQUASH_CYCLES (SQ),
      .LD_MEM        (3'b001)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: recent register writes, newest first, plus squash/bubble bookkeeping
   int m_valid [3];
   int m_rd    [3];
   int m_load  [3];
   int m_rem;
   int m_bub;
   int e_haz, e_sq, e_hold, e_fa, e_fb;

   function automatic int mhit(int i, int s);
      return (m_valid[i] != 0 && m_rd[i] == s && s != 0) ? 1 : 0;
   endfunction

   function automatic int youngest_src(int s);
      for (int i = 0; i < 3; i++)
         if (mhit(i, s) != 0) return i + 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = 0;
         m_rd[i]    = 0;
         m_load[i]  = 0;
      end
      m_rem = 0;
      m_bub = 0;
   endtask

   task automatic model_eval();
      int s0, s1, jumping;
      s0 = int'(ifc.a0);
      s1 = int'(ifc.a1);
`ifdef HAZARD_FORWARD_EN
      e_haz = ((mhit(0, s0) != 0 || mhit(0, s1) != 0) && m_load[0] != 0) ? 1 : 0;
      e_fa  = youngest_src(s0);
      e_fb  = youngest_src(s1);
`else
      e_haz = 0;
      for (int i = 0; i < 3; i++)
         if (mhit(i, s0) != 0 || mhit(i, s1) != 0) e_haz = 1;
      e_fa = 0;
      e_fb = 0;
`endif
      jumping = (ifc.jmp_taken || m_rem > 0) ? 1 : 0;
      e_sq    = (jumping != 0 || e_haz != 0) ? 1 : 0;
      e_hold  = (ifc.mem_busy || (e_haz != 0 && jumping == 0)) ? 1 : 0;
   endtask

   task automatic model_step();
      int jumping;
      jumping = (ifc.jmp_taken || m_rem > 0) ? 1 : 0;
      if (e_haz != 0 && jumping == 0 && !ifc.mem_busy && m_bub < 65535) m_bub++;
      if (ifc.jmp_taken)              m_rem = int'(SQ) - 1;
      else if (!ifc.mem_busy && m_rem > 0) m_rem--;
      if (!ifc.mem_busy) begin
         for (int i = 2; i > 0; i--) begin
            m_valid[i] = m_valid[i-1];
            m_rd[i]    = m_rd[i-1];
            m_load[i]  = m_load[i-1];
         end
         m_valid[0] = (ifc.dec_en_reg_wr && e_sq == 0) ? 1 : 0;
         m_rd[0]    = int'(ifc.a2_hazard);
         m_load[0]  = (int'(ifc.dec_ld_code) == LD_VAL) ? 1 : 0;
      end
   endtask

   // Drive one decode cycle and compare every output against the model
   task automatic apply(input int a0, input int a1, input int a2, input int en,
                        input int ld, input int jmp, input int busy);
      ifc.a0            = 5'(a0);
      ifc.a1            = 5'(a1);
      ifc.a2_hazard     = 5'(a2);
      ifc.dec_en_reg_wr = 1'(en);
      ifc.dec_ld_code   = 3'(ld);
      ifc.jmp_taken     = 1'(jmp);
      ifc.mem_busy      = 1'(busy);
      #2;
      model_eval();
      check("dec_stall",  32'(ifc.dec_stall),  32'(busy));
      check("dec_squash", 32'(ifc.dec_squash), 32'(e_sq));
      check("hold_fetch", 32'(ifc.hold_fetch), 32'(e_hold));
      check("fwd_sel_a",  32'(ifc.fwd_sel_a),  32'(e_fa));
      check("fwd_sel_b",  32'(ifc.fwd_sel_b),  32'(e_fb));
      check("bubble_cnt", 32'(ifc.bubble_cnt), 32'(m_bub));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      apply(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      n_cmp = 0;
      n_err = 0;
      model_reset();

      // Reset with idle inputs
      rst = 1'b0;
      ifc.a0 = '0; ifc.a1 = '0; ifc.a2_hazard = '0; ifc.dec_en_reg_wr = 1'b0;
      ifc.dec_ld_code = '0; ifc.jmp_taken = 1'b0; ifc.mem_busy = 1'b0;
      @(posedge clk); #1;
      check("rst_squash", 32'(ifc.dec_squash), 0);
      check("rst_hold",   32'(ifc.hold_fetch), 0);
      check("rst_stall",  32'(ifc.dec_stall),  0);
      check("rst_bubble", 32'(ifc.bubble_cnt), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      idle(); tick();
      idle(); tick();

`ifdef HAZARD_FORWARD_EN
      // Load into x5, then a consumer: one bubble, then forward from MEM
      apply(0, 0, 5, 1, LD_VAL, 0, 0); tick();
      apply(5, 0, 0, 0, 0, 0, 0);
      check("lu_hold", 32'(ifc.hold_fetch), 1);
      check("lu_squash", 32'(ifc.dec_squash), 1);
      tick();
      apply(5, 0, 0, 0, 0, 0, 0);
      check("lu_hold_rel", 32'(ifc.hold_fetch), 0);
      check("lu_fwd_a", 32'(ifc.fwd_sel_a), 2);
      check("lu_bubbles", 32'(ifc.bubble_cnt), 1);
      tick();
`else
      // Add into x7, then a consumer: three bubbles, then release
      apply(0, 0, 7, 1, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         apply(0, 7, 0, 0, 0, 0, 0);
         check("il_hold", 32'(ifc.hold_fetch), 1);
         check("il_squash", 32'(ifc.dec_squash), 1);
         tick();
      end
      apply(0, 7, 0, 0, 0, 0, 0);
      check("il_hold_rel", 32'(ifc.hold_fetch), 0);
      check("il_fwd_b", 32'(ifc.fwd_sel_b), 0);
      check("il_bubbles", 32'(ifc.bubble_cnt), 3);
      tick();
`endif
      idle(); tick(); idle(); tick(); idle(); tick();

      // Jump concurrent with a pending hazard: squash wins, no bubble counted
      b0 = m_bub;
      apply(0, 0, 7, 1, LD_VAL, 0, 0); tick();
      apply(0, 7, 0, 0, 0, 1, 0);
      check("jmp_squash0", 32'(ifc.dec_squash), 1);
      check("jmp_hold0", 32'(ifc.hold_fetch), 0);
      tick();
      apply(0, 7, 0, 0, 0, 0, 0);
      check("jmp_squash1", 32'(ifc.dec_squash), 1);
      check("jmp_hold1", 32'(ifc.hold_fetch), 0);
      tick();
      idle();
      check("jmp_squash_end", 32'(ifc.dec_squash), 0);
      check("jmp_bubbles", 32'(ifc.bubble_cnt), 32'(b0));
      tick();
      idle(); tick(); idle(); tick();

      // Memory busy freezes the scoreboard with x9 in EX
      apply(0, 0, 9, 1, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 0, 0, 0, 0, 1);
         check("busy_stall", 32'(ifc.dec_stall), 1);
         check("busy_hold", 32'(ifc.hold_fetch), 1);
         tick();
      end
      apply(9, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
      check("busy_x9_in_ex", 32'(ifc.fwd_sel_a), 1);
`else
      check("busy_x9_in_ex", 32'(ifc.hold_fetch), 1);
`endif
      tick();
      idle(); tick(); idle(); tick(); idle(); tick();

      // Register 0 never matches
      apply(0, 0, 0, 1, LD_VAL, 0, 0); tick();
      apply(0, 0, 0, 0, 0, 0, 0);
      check("x0_hold", 32'(ifc.hold_fetch), 0);
      check("x0_squash", 32'(ifc.dec_squash), 0);
      tick();

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         apply(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 1 : 0,
               ($urandom_range(0, 5) == 0) ? 1 : 0);
         tick();
      end

      // Reset in the middle of a squash aborts it at once
      idle(); tick(); idle(); tick();
      apply(0, 0, 0, 0, 0, 1, 0); tick();
      idle();
      check("mid_squash", 32'(ifc.dec_squash), 1);
      rst = 1'b0;
      #1;
      check("rst_mid_squash", 32'(ifc.dec_squash), 0);
      check("rst_mid_bubble", 32'(ifc.bubble_cnt), 0);
      model_reset();
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      idle(); tick();
      idle(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
